// File: rtl/memory_game_ctrl_pkg.sv
// rtl/memory_game_ctrl_pkg.sv - shared card types and constants for the memory game
package memory_game_ctrl_pkg;

  localparam int N_CARDS = 16;
  localparam int N_PAIRS = 8;

  typedef enum logic [1:0] {
    CARD_HIDDEN  = 2'd0,
    CARD_UP      = 2'd1,
    CARD_MATCHED = 2'd2
  } card_state_e;

  typedef card_state_e [N_CARDS-1:0] card_vec_t;

  function automatic card_vec_t all_hidden();
    card_vec_t v;
    for (int i = 0; i < N_CARDS; i++) v[i] = CARD_HIDDEN;
    return v;
  endfunction

  // 0 = player 0 ahead, 1 = player 1 ahead, 2 = tie
  function automatic logic [1:0] pick_winner(input logic [3:0] s0, input logic [3:0] s1);
    if (s0 > s1) return 2'd0;
    if (s1 > s0) return 2'd1;
    return 2'd2;
  endfunction

endpackage

// File: rtl/memory_game_ctrl_if.sv
// rtl/memory_game_ctrl_if.sv - button/symbol inputs and draw-stage outputs of the game controller
interface memory_game_ctrl_if;
  import memory_game_ctrl_pkg::*;

  logic                  start;
  logic                  btn_left;
  logic                  btn_right;
  logic                  btn_sel;
  logic [15:0][3:0]      symbol_id;
  card_vec_t             state;
  logic [3:0]            hi;
  logic                  player;
  logic [3:0]            score0;
  logic [3:0]            score1;
  logic [4:0]            time_left;
  logic                  game_over;
  logic [1:0]            winner;

  modport master (
    output start, btn_left, btn_right, btn_sel, symbol_id,
    input  state, hi, player, score0, score1, time_left, game_over, winner
  );

  modport slave (
    input  start, btn_left, btn_right, btn_sel, symbol_id,
    output state, hi, player, score0, score1, time_left, game_over, winner
  );
endinterface

// File: rtl/memory_game_ctrl_turn_timer.sv
// rtl/memory_game_ctrl_turn_timer.sv - 1 s prescaler plus per-turn seconds down-counter
module turn_timer #(
  parameter int CLK_HZ   = 25_000_000,
  parameter int TURN_SEC = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       en_i,
  output logic       expire_o,
  output logic [4:0] time_left_o
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    sec_q, sec_d;
  logic          tick;

  assign tick        = en_i && (presc_q == PW'(CLK_HZ - 1));
  assign expire_o    = tick && (sec_q == 5'd1);
  assign time_left_o = sec_q;

  // load wins over counting so a new turn always starts from a clean prescaler
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (load_i) begin
      presc_d = '0;
      sec_d   = 5'(TURN_SEC);
    end else if (en_i) begin
      if (tick) begin
        presc_d = '0;
        if (sec_q != 5'd0) sec_d = sec_q - 5'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      sec_q   <= 5'(TURN_SEC);
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end
endmodule

// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - turn/flip controller for the 16-card two-player memory game
module memory_game_ctrl
  import memory_game_ctrl_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int TURN_SEC    = 15,
  parameter int SHOW_CYCLES = 25_000_000
) (
  input logic               clk,
  input logic               rst_n,
  memory_game_ctrl_if.slave gif
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PICK1 = 3'd1;
  localparam logic [2:0] S_PICK2 = 3'd2;
  localparam logic [2:0] S_SHOW  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  logic [2:0]    fsm_q, fsm_d;
  card_vec_t     card_q, card_d;
  logic [3:0]    hi_q, hi_d, first_q, first_d, second_q, second_d;
  logic [3:0]    score0_q, score0_d, score1_q, score1_d;
  logic          player_q, player_d, over_q, over_d;
  logic [1:0]    winner_q, winner_d;
  logic [SW-1:0] show_q, show_d;
  logic          in_pick, sel_ok, timer_load, expire;
  logic [4:0]    total;

  turn_timer #(.CLK_HZ(CLK_HZ), .TURN_SEC(TURN_SEC)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (timer_load),
    .en_i        (in_pick),
    .expire_o    (expire),
    .time_left_o (gif.time_left)
  );

  assign in_pick = (fsm_q == S_PICK1) || (fsm_q == S_PICK2);
  // a timeout in the same cycle as a select takes precedence over the flip
  assign sel_ok  = in_pick && !expire && gif.btn_sel && (card_q[hi_q] == CARD_HIDDEN);

  always_comb begin
    fsm_d      = fsm_q;
    card_d     = card_q;
    hi_d       = hi_q;
    first_d    = first_q;
    second_d   = second_q;
    score0_d   = score0_q;
    score1_d   = score1_q;
    player_d   = player_q;
    over_d     = over_q;
    winner_d   = winner_q;
    show_d     = show_q;
    timer_load = 1'b0;
    total      = 5'd0;
    if (gif.start) begin
      fsm_d      = S_PICK1;
      card_d     = all_hidden();
      hi_d       = 4'd0;
      score0_d   = 4'd0;
      score1_d   = 4'd0;
      player_d   = 1'b0;
      over_d     = 1'b0;
      winner_d   = 2'd0;
      timer_load = 1'b1;
    end else begin
      case (fsm_q)
        S_PICK1, S_PICK2: begin
          if (!gif.btn_sel && (gif.btn_left ^ gif.btn_right))
            hi_d = gif.btn_right ? hi_q + 4'd1 : hi_q - 4'd1;
          if (expire) begin
            if (fsm_q == S_PICK2) card_d[first_q] = CARD_HIDDEN;
            player_d   = ~player_q;
            fsm_d      = S_PICK1;
            timer_load = 1'b1;
          end else if (sel_ok) begin
            card_d[hi_q] = CARD_UP;
            if (fsm_q == S_PICK1) begin
              first_d = hi_q;
              fsm_d   = S_PICK2;
            end else begin
              second_d = hi_q;
              show_d   = SW'(SHOW_CYCLES - 1);
              fsm_d    = S_SHOW;
            end
          end
        end
        S_SHOW: begin
          if (show_q == '0) fsm_d = S_CHECK;
          else show_d = show_q - 1'b1;
        end
        S_CHECK: begin
          if (gif.symbol_id[first_q] == gif.symbol_id[second_q]) begin
            card_d[first_q]  = CARD_MATCHED;
            card_d[second_q] = CARD_MATCHED;
            if (player_q) score1_d = score1_q + 4'd1;
            else          score0_d = score0_q + 4'd1;
            total = {1'b0, score0_d} + {1'b0, score1_d};
            if (total == 5'(N_PAIRS)) begin
              fsm_d    = S_DONE;
              over_d   = 1'b1;
              winner_d = pick_winner(score0_d, score1_d);
            end else begin
              fsm_d      = S_PICK1;
              timer_load = 1'b1;
            end
          end else begin
            card_d[first_q]  = CARD_HIDDEN;
            card_d[second_q] = CARD_HIDDEN;
            player_d         = ~player_q;
            fsm_d            = S_PICK1;
            timer_load       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      card_q   <= all_hidden();
      hi_q     <= 4'd0;
      first_q  <= 4'd0;
      second_q <= 4'd0;
      score0_q <= 4'd0;
      score1_q <= 4'd0;
      player_q <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 2'd0;
      show_q   <= '0;
    end else begin
      fsm_q    <= fsm_d;
      card_q   <= card_d;
      hi_q     <= hi_d;
      first_q  <= first_d;
      second_q <= second_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      player_q <= player_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      show_q   <= show_d;
    end
  end

  assign gif.state     = card_q;
  assign gif.hi        = hi_q;
  assign gif.player    = player_q;
  assign gif.score0    = score0_q;
  assign gif.score1    = score1_q;
  assign gif.game_over = over_q;
  assign gif.winner    = winner_q;
endmodule

// File: tb/tb_memory_game_ctrl.sv
// tb/tb_memory_game_ctrl.sv - scoreboard bench for memory_game_ctrl against a turn-level reference model
module tb_memory_game_ctrl;
  import memory_game_ctrl_pkg::*;

  localparam int CLK_HZ      = 10;
  localparam int TURN_SEC    = 3;
  localparam int SHOW_CYCLES = 4;
  localparam int TURN_CYC    = CLK_HZ * TURN_SEC;
  localparam int PH_IDLE = 0, PH_FIRST = 1, PH_SECOND = 2, PH_SHOW = 3, PH_CHECK = 4, PH_OVER = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_game_ctrl_if gif();

  memory_game_ctrl #(.CLK_HZ(CLK_HZ), .TURN_SEC(TURN_SEC), .SHOW_CYCLES(SHOW_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gif   (gif)
  );

  typedef struct {
    logic [31:0] cards;
    int hi; int player; int s0; int s1; int tl; int over; int win;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: turn phase, elapsed play cycles in the turn, cards as ints
  int m_phase, m_hi, m_player, m_first, m_second, m_elapsed, m_show, m_over, m_win;
  int m_cards[16];
  int m_score[2];
  int sym[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.cards = '0;
    for (int i = 0; i < 16; i++) s.cards[2*i +: 2] = 2'(m_cards[i]);
    s.hi = m_hi; s.player = m_player; s.s0 = m_score[0]; s.s1 = m_score[1];
    s.tl = TURN_SEC - m_elapsed / CLK_HZ;
    s.over = m_over; s.win = m_win;
    return s;
  endfunction

  task automatic compare_snap(input snap_t e);
    logic [31:0] a;
    a = gif.state;
    chk("state", int'(a), int'(e.cards));
    chk("hi", int'(gif.hi), e.hi);
    chk("player", int'(gif.player), e.player);
    chk("score0", int'(gif.score0), e.s0);
    chk("score1", int'(gif.score1), e.s1);
    chk("time_left", int'(gif.time_left), e.tl);
    chk("game_over", int'(gif.game_over), e.over);
    chk("winner", int'(gif.winner), e.win);
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_hi = 0; m_player = 0; m_first = 0; m_second = 0;
    m_elapsed = 0; m_show = 0; m_over = 0; m_win = 0;
    m_score[0] = 0; m_score[1] = 0;
    for (int i = 0; i < 16; i++) m_cards[i] = 0;
  endtask

  task automatic model_step(input bit st, input bit l, input bit r, input bit s);
    int h;
    if (st) begin
      model_reset();
      m_phase = PH_FIRST;
      return;
    end
    case (m_phase)
      PH_FIRST, PH_SECOND: begin
        h = m_hi;
        if (!s && (l != r)) m_hi = r ? (m_hi + 1) % 16 : (m_hi + 15) % 16;
        if (m_elapsed + 1 == TURN_CYC) begin
          if (m_phase == PH_SECOND) m_cards[m_first] = 0;
          m_player = 1 - m_player;
          m_phase = PH_FIRST;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (s && m_cards[h] == 0) begin
            m_cards[h] = 1;
            if (m_phase == PH_FIRST) begin m_first = h; m_phase = PH_SECOND; end
            else begin m_second = h; m_phase = PH_SHOW; m_show = 0; end
          end
        end
      end
      PH_SHOW: begin
        m_show++;
        if (m_show == SHOW_CYCLES) m_phase = PH_CHECK;
      end
      PH_CHECK: begin
        if (sym[m_first] == sym[m_second]) begin
          m_cards[m_first] = 2; m_cards[m_second] = 2;
          m_score[m_player]++;
          if (m_score[0] + m_score[1] == 8) begin
            m_phase = PH_OVER; m_over = 1;
            m_win = (m_score[0] > m_score[1]) ? 0 : (m_score[1] > m_score[0]) ? 1 : 2;
          end else begin
            m_phase = PH_FIRST; m_elapsed = 0;
          end
        end else begin
          m_cards[m_first] = 0; m_cards[m_second] = 0;
          m_player = 1 - m_player;
          m_phase = PH_FIRST; m_elapsed = 0;
        end
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare_snap(e);
    end
  end

  task automatic step(input bit st, input bit l, input bit r, input bit s);
    gif.start = st; gif.btn_left = l; gif.btn_right = r; gif.btn_sel = s;
    @(posedge clk);
    model_step(st, l, r, s);
    exp_q.push_back(model_snap());
    #1;
    gif.start = 1'b0; gif.btn_left = 1'b0; gif.btn_right = 1'b0; gif.btn_sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic goto_card(input int t);
    int guard;
    guard = 0;
    while (m_hi != t && guard < 20) begin
      if (((t - m_hi + 16) % 16) <= 8) step(0, 0, 1, 0);
      else step(0, 1, 0, 0);
      guard++;
    end
  endtask

  task automatic pick(input int t);
    goto_card(t);
    step(0, 0, 0, 1);
  endtask

  task automatic pick_pair(input int a, input int b);
    pick(a);
    pick(b);
    idle(SHOW_CYCLES + 1);
  endtask

  task automatic set_deal(input int d[16]);
    for (int i = 0; i < 16; i++) begin
      sym[i] = d[i];
      gif.symbol_id[i] = 4'(d[i]);
    end
  endtask

  task automatic deal_random();
    int d[16];
    int j, t;
    for (int i = 0; i < 16; i++) d[i] = i / 2;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = d[i]; d[i] = d[j]; d[j] = t;
    end
    set_deal(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fixed[16] = '{0, 0, 1, 2, 1, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7};
    int p0, n;
    gif.start = 0; gif.btn_left = 0; gif.btn_right = 0; gif.btn_sel = 0;
    set_deal(fixed);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_snap(model_snap());
    @(negedge clk);
    #1 rst_n = 1'b1;

    // matched pair keeps the turn; match lands five edges after the second select
    step(1, 0, 0, 0);
    pick(0);
    pick(1);
    idle(SHOW_CYCLES);
    chk("still_up_before_check", int'(gif.state[1]), int'(CARD_UP));
    idle(1);
    chk("pair_matched0", int'(gif.state[0]), int'(CARD_MATCHED));
    chk("pair_matched1", int'(gif.state[1]), int'(CARD_MATCHED));
    chk("match_score0", int'(gif.score0), 1);
    chk("match_player", int'(gif.player), 0);

    pick_pair(2, 3);
    chk("mismatch_hidden", int'(gif.state[2]), int'(CARD_HIDDEN));
    chk("mismatch_player", int'(gif.player), 1);
    chk("mismatch_time", int'(gif.time_left), TURN_SEC);

    goto_card(0);
    step(0, 1, 0, 0);
    chk("wrap_left", int'(gif.hi), 15);
    goto_card(0);
    step(0, 0, 0, 1);
    chk("sel_matched_ignored", int'(gif.state[0]), int'(CARD_MATCHED));
    step(0, 1, 1, 0);
    chk("left_right_nomove", int'(gif.hi), 0);

    // single pick then let the turn run out
    pick(5);
    p0 = gif.player;
    n = 0;
    while (gif.player == p0 && n < 40) begin
      step(0, 0, 0, 0);
      n++;
    end
    chk("timeout_seen", int'(n < 40), 1);
    chk("timeout_card_hidden", int'(gif.state[5]), int'(CARD_HIDDEN));
    chk("timeout_player", int'(gif.player), 0);
    chk("timeout_time", int'(gif.time_left), TURN_SEC);

    // asynchronous reset while both cards are face up
    pick(2);
    pick(4);
    idle(1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_snap(model_snap());
    @(negedge clk);
    #1 rst_n = 1'b1;

    // scripted full game: P0 takes five pairs, P1 three
    step(1, 0, 0, 0);
    pick_pair(0, 1);
    pick_pair(2, 4);
    pick_pair(3, 5);
    pick_pair(6, 7);
    pick_pair(8, 9);
    pick_pair(10, 12);
    pick_pair(10, 11);
    pick_pair(12, 13);
    pick_pair(14, 15);
    chk("game_over", int'(gif.game_over), 1);
    chk("winner_p0", int'(gif.winner), 0);
    chk("final_score0", int'(gif.score0), 5);
    chk("final_score1", int'(gif.score1), 3);
    idle(3);
    step(1, 0, 0, 0);
    chk("restart_hidden", int'(32'(gif.state)), 0);
    chk("restart_score0", int'(gif.score0), 0);
    chk("restart_over", int'(gif.game_over), 0);

    for (int g = 0; g < 6; g++) begin
      deal_random();
      step(1, 0, 0, 0);
      for (int c = 0; c < 400; c++) begin
        step($urandom_range(299, 0) == 0, $urandom_range(3, 0) == 0,
             $urandom_range(3, 0) == 0, $urandom_range(2, 0) == 0);
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
